pipeline_ctrl: RTL and testbench

Control-path sequencer for the 5-stage LEGv8 datapath. Accepts decoded control from the ID stage and carries it through the ID/EX, EX/MEM and MEM/WB control registers, aligned with the datapath cutsets. Generates the forward_Da/forward_Db selects and the write-back address (Rd2). Detects load-use hazards and holds fetch/decode for one cycle while injecting a bubble into EX.

---
 rtl/pipeline_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// LEGv8 5-stage control-path sequencer: ID/EX, EX/MEM, MEM/WB control registers,
// operand forwarding selects and load-use stall. Define PIPE_PERF_CNT_EN for perf counters.
module pipeline_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 31,
  localparam int unsigned AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_Rn,
  input  logic [AW-1:0] id_Ab,
  input  logic          id_uses_Da,
  input  logic          id_uses_Db,
  input  logic [AW-1:0] id_Rd,
  input  logic          id_RegWren,
  input  logic          id_MemWren,
  input  logic          id_is_load,
  input  logic          id_Shift2Reg,
  input  logic          id_SetFlags,
  input  logic [2:0]    id_ALU_Op,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    forward_Da,
  output logic [1:0]    forward_Db,
  output logic [2:0]    ex_ALU_Op,
  output logic          ex_Shift2Reg,
  output logic          ex_SetFlags,
  output logic          mem_MemWren,
  output logic          mem_Mem2Reg,
  output logic          wb_RegWren,
  output logic [AW-1:0] wb_Rd
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]   stall_count,
  output logic [31:0]   bubble_count,
  output logic [31:0]   fwd_count
`endif
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          reg_wren;
    logic          mem_wren;
    logic          is_load;
    logic          shift2reg;
    logic          set_flags;
    logic [2:0]    alu_op;
  } ex_stage_t;

  // Later stages keep only the fields something downstream still reads;
  // the EX-only controls would be dead flops past EX.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          reg_wren;
    logic          mem_wren;
    logic          is_load;
  } mem_stage_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          reg_wren;
  } wb_stage_t;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  logic     ex_writes, mem_writes, ex_fwd_ok;
  logic     stall_c, bubble;
  fwd_sel_e fwd_a, fwd_b;

  function automatic fwd_sel_e fwd_select(
    input logic [AW-1:0] addr,
    input logic          ex_src,
    input logic [AW-1:0] ex_rd,
    input logic          mem_src,
    input logic [AW-1:0] mem_rd
  );
    if (ex_src && (ex_rd == addr))
      return FWD_EX;
    else if (mem_src && (mem_rd == addr))
      return FWD_MEM;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    ex_writes  = ex_q.valid  & ex_q.reg_wren  & (ex_q.rd  != ZR);
    mem_writes = mem_q.valid & mem_q.reg_wren & (mem_q.rd != ZR);
    ex_fwd_ok  = ex_writes & ~ex_q.is_load;

    fwd_a = fwd_select(id_Rn, ex_fwd_ok, ex_q.rd, mem_writes, mem_q.rd);
    fwd_b = fwd_select(id_Ab, ex_fwd_ok, ex_q.rd, mem_writes, mem_q.rd);

    stall_c = id_valid & ~flush & ex_writes & ex_q.is_load &
              ((id_uses_Da & (ex_q.rd == id_Rn)) |
               (id_uses_Db & (ex_q.rd == id_Ab)));
    bubble  = ~id_valid | flush | stall_c;
  end

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_Rd;
      ex_d.reg_wren  = id_RegWren;
      ex_d.mem_wren  = id_MemWren;
      ex_d.is_load   = id_is_load;
      ex_d.shift2reg = id_Shift2Reg;
      ex_d.set_flags = id_SetFlags;
      ex_d.alu_op    = id_ALU_Op;
    end

    mem_d.valid    = ex_q.valid;
    mem_d.rd       = ex_q.rd;
    mem_d.reg_wren = ex_q.reg_wren;
    mem_d.mem_wren = ex_q.mem_wren;
    mem_d.is_load  = ex_q.is_load;

    wb_d.valid     = mem_q.valid;
    wb_d.rd        = mem_q.rd;
    wb_d.reg_wren  = mem_q.reg_wren;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign stall        = stall_c;
  assign forward_Da   = fwd_a;
  assign forward_Db   = fwd_b;
  assign ex_ALU_Op    = ex_q.alu_op;
  assign ex_Shift2Reg = ex_q.shift2reg;
  assign ex_SetFlags  = ex_q.set_flags;
  assign mem_MemWren  = mem_q.mem_wren;
  // Qualified by valid so an empty MEM slot (reset or bubble) reads back as 0.
  assign mem_Mem2Reg  = mem_q.valid & ~mem_q.is_load;
  assign wb_RegWren   = wb_q.valid & wb_q.reg_wren;
  assign wb_Rd        = wb_q.rd;

`ifdef PIPE_PERF_CNT_EN
  logic fwd_used;

  assign fwd_used = ((fwd_a != FWD_RF) & id_uses_Da) |
                    ((fwd_b != FWD_RF) & id_uses_Db);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count  <= '0;
      bubble_count <= '0;
      fwd_count    <= '0;
    end else begin
      if (stall_c)  stall_count  <= stall_count  + 32'd1;
      if (bubble)   bubble_count <= bubble_count + 32'd1;
      if (fwd_used) fwd_count    <= fwd_count    + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: forwarding, load-use stall,
// flush priority and asynchronous reset discard.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_Rn, id_Ab, id_Rd;
  logic       id_uses_Da, id_uses_Db;
  logic       id_RegWren, id_MemWren, id_is_load, id_Shift2Reg, id_SetFlags;
  logic [2:0] id_ALU_Op;
  logic       flush;
  logic       stall;
  logic [1:0] forward_Da, forward_Db;
  logic [2:0] ex_ALU_Op;
  logic       ex_Shift2Reg, ex_SetFlags;
  logic       mem_MemWren, mem_Mem2Reg, wb_RegWren;
  logic [4:0] wb_Rd;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_count, bubble_count, fwd_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NUM_REGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_Rn(id_Rn), .id_Ab(id_Ab),
    .id_uses_Da(id_uses_Da), .id_uses_Db(id_uses_Db),
    .id_Rd(id_Rd), .id_RegWren(id_RegWren), .id_MemWren(id_MemWren),
    .id_is_load(id_is_load), .id_Shift2Reg(id_Shift2Reg),
    .id_SetFlags(id_SetFlags), .id_ALU_Op(id_ALU_Op), .flush(flush),
    .stall(stall), .forward_Da(forward_Da), .forward_Db(forward_Db),
    .ex_ALU_Op(ex_ALU_Op), .ex_Shift2Reg(ex_Shift2Reg), .ex_SetFlags(ex_SetFlags),
    .mem_MemWren(mem_MemWren), .mem_Mem2Reg(mem_Mem2Reg),
    .wb_RegWren(wb_RegWren), .wb_Rd(wb_Rd)
`ifdef PIPE_PERF_CNT_EN
    , .stall_count(stall_count), .bubble_count(bubble_count), .fwd_count(fwd_count)
`endif
  );

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] ab,
                       input logic uda, input logic udb, input logic [4:0] rd,
                       input logic regw, input logic memw, input logic ld,
                       input logic s2r, input logic sf, input logic [2:0] op);
    id_valid = v;   id_Rn = rn;  id_Ab = ab;  id_uses_Da = uda; id_uses_Db = udb;
    id_Rd = rd;     id_RegWren = regw;  id_MemWren = memw;  id_is_load = ld;
    id_Shift2Reg = s2r;  id_SetFlags = sf;  id_ALU_Op = op;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  logic [15:0] all_out;
  assign all_out = {stall, forward_Da, forward_Db, ex_ALU_Op, ex_Shift2Reg, ex_SetFlags,
                    mem_MemWren, mem_Mem2Reg, wb_RegWren, wb_Rd[2:0]};

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();

    // Reset held three cycles, then idle pipeline drains to all-zero outputs.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_all_zero", all_out === 16'h0, all_out, 16'h0);
    chk("reset_wb_rd", wb_Rd === 5'd0, wb_Rd, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_idle", all_out === 16'h0, all_out, 16'h0);
    end

    // ADDI X1 ; ADD X2,X1,X3 -> EX forward on Da.
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    chk("addi_no_fwd", forward_Da === 2'b00, forward_Da, 2'b00);
    tick();
    chk("addi_ex_op", ex_ALU_Op === 3'b010, ex_ALU_Op, 3'b010);
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    chk("add_fwd_da_ex", forward_Da === 2'b10, forward_Da, 2'b10);
    chk("add_fwd_db_rf", forward_Db === 2'b00, forward_Db, 2'b00);
    chk("add_no_stall", stall === 1'b0, stall, 1'b0);
    tick();
    chk("addi_mem2reg", mem_Mem2Reg === 1'b1, mem_Mem2Reg, 1'b1);
    chk("addi_mem_memwren", mem_MemWren === 1'b0, mem_MemWren, 1'b0);
    idle();
    tick();
    chk("addi_wb_regwren", wb_RegWren === 1'b1, wb_RegWren, 1'b1);
    chk("addi_wb_rd", wb_Rd === 5'd1, wb_Rd, 5'd1);
    // Reader of X2 (ADD now in MEM) and X1 (ADDI now in WB, no forwarding).
    drive(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    chk("mem_fwd_da", forward_Da === 2'b01, forward_Da, 2'b01);
    chk("wb_no_fwd_db", forward_Db === 2'b00, forward_Db, 2'b00);
    tick();

    // LDUR X4 ; SUB X5,X6,X4 -> one stall cycle then MEM forward.
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    tick();
    drive(1'b1, 5'd6, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
    chk("ldu_stall", stall === 1'b1, stall, 1'b1);
    chk("ldu_no_ex_fwd", forward_Db === 2'b00, forward_Db, 2'b00);
    tick();
    chk("ldu_bubble_setflags", ex_SetFlags === 1'b0, ex_SetFlags, 1'b0);
    chk("ldu_bubble_op", ex_ALU_Op === 3'b000, ex_ALU_Op, 3'b000);
    chk("ldu_mem2reg_load", mem_Mem2Reg === 1'b0, mem_Mem2Reg, 1'b0);
    chk("ldu_stall_released", stall === 1'b0, stall, 1'b0);
    chk("ldu_fwd_db_mem", forward_Db === 2'b01, forward_Db, 2'b01);
    chk("ldu_fwd_da_rf", forward_Da === 2'b00, forward_Da, 2'b00);
    tick();
    chk("sub_ex_setflags", ex_SetFlags === 1'b1, ex_SetFlags, 1'b1);
    chk("sub_ex_op", ex_ALU_Op === 3'b011, ex_ALU_Op, 3'b011);
    chk("ldur_wb_rd", wb_Rd === 5'd4, wb_Rd, 5'd4);
    chk("ldur_wb_regwren", wb_RegWren === 1'b1, wb_RegWren, 1'b1);

    // Two writers of X7, then a reader: EX wins over MEM.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
    tick();
    chk("x7_ex_shift2reg", ex_Shift2Reg === 1'b1, ex_Shift2Reg, 1'b1);
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    chk("x7_fwd_da_ex_prio", forward_Da === 2'b10, forward_Da, 2'b10);
    chk("x7_fwd_db_ex_prio", forward_Db === 2'b10, forward_Db, 2'b10);
    tick();

    // LDUR X31 then read X31: zero register never forwards or stalls.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    tick();
    drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    chk("x31_fwd_da", forward_Da === 2'b00, forward_Da, 2'b00);
    chk("x31_fwd_db", forward_Db === 2'b00, forward_Db, 2'b00);
    chk("x31_no_stall", stall === 1'b0, stall, 1'b0);
    tick();

    // LDUR X8 then a dependent with flush: flush wins, bubble, no write-back.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101);
    chk("flush_no_stall", stall === 1'b0, stall, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_bubble_op", ex_ALU_Op === 3'b000, ex_ALU_Op, 3'b000);
    chk("flush_bubble_setflags", ex_SetFlags === 1'b0, ex_SetFlags, 1'b0);
    tick();
    chk("flush_mem_memwren", mem_MemWren === 1'b0, mem_MemWren, 1'b0);
    chk("ldur8_wb_rd", wb_Rd === 5'd8, wb_Rd, 5'd8);
    chk("ldur8_wb_regwren", wb_RegWren === 1'b1, wb_RegWren, 1'b1);
    tick();
    chk("flush_no_wb", wb_RegWren === 1'b0, wb_RegWren, 1'b0);

    // Writer X12 then a store; reset while the store sits in EX.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
    tick();
    idle();
    chk("pre_reset_ex_op", ex_ALU_Op === 3'b110, ex_ALU_Op, 3'b110);
    chk("pre_reset_mem2reg", mem_Mem2Reg === 1'b1, mem_Mem2Reg, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", all_out === 16'h0, all_out, 16'h0);
    tick();
    chk("reset_hold_memwren", mem_MemWren === 1'b0, mem_MemWren, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_memwren", mem_MemWren === 1'b0, mem_MemWren, 1'b0);
      chk("post_reset_wb_regwren", wb_RegWren === 1'b0, wb_RegWren, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
